ahb_arbiter: RTL and testbench
==============================

Name: ahb_arbiter

Overview:
- Shares one AHB-Lite slave port among NM AHB master models using round-robin arbitration, with lock support and a per-owner hold limit.
- Tracks the address-phase owner and the data-phase owner separately.
- Muxes the address/control of the address-phase owner and the write data of the data-phase owner onto the shared bus.
- Sits between the master VIP instances and the slave VIP / Avalon bridge in the bus test environment.

Parameters:
- NM, 4, number of masters (2..8).
- MIW, 3, master index width; NM <= 2**MIW.
- DW, 32, data width.
- AW, 32, address width.
- MAXHOLD, 16, max hready-qualified cycles an unlocked owner keeps the grant while others request; 0 disables the limit.

Ports:
- hclk  in  1  clock, rising edge.
- hreset  in  1  synchronous, active-high reset.
- hbusreq  in  NM  per-master bus request.
- hlock  in  NM  per-master lock request.
- m_haddr  in  NM*AW  master addresses; master i at [i*AW +: AW].
- m_htrans  in  NM*2  master htrans.
- m_hsize  in  NM*3  master hsize.
- m_hwrite  in  NM  master hwrite.
- m_hwdata  in  NM*DW  master write data.
- hready  in  1  slave ready.
- hgrant  out  NM  one-hot grant.
- hmaster  out  MIW  address-phase owner index.
- hmastlock  out  1  locked transfer indicator.
- haddr  out  AW  muxed address.
- htrans  out  2  muxed htrans.
- hsize  out  3  muxed hsize.
- hwrite  out  1  muxed hwrite.
- hwdata  out  DW  muxed write data, selected by the data-phase owner.

Behaviour:
- Reset (registered outputs, next edge):
  - hgrant=1 (master 0, the default master).
  - hmaster=0, data owner=0, hmastlock=0, hold counter=0, last-winner pointer=0.
  - Muxed outputs then reflect master 0 combinationally.
- Reset asserted mid-burst: all state returns to reset values at the next edge; no transfer completion is tracked.
- State (registers):
  - grant_idx: granted master.
  - addr_owner (= hmaster).
  - data_owner.
  - lock_q.
  - hold_cnt.
- Handover:
  - All updates are qualified by hready=1; with hready=0 every register holds.
  - On an hready=1 edge: data_owner<=addr_owner, addr_owner<=grant_idx, hmastlock<=hlock[grant_idx] & (m_htrans[grant_idx]!=IDLE).
  - Result: a new grant appears on hgrant one hready cycle before the new master owns the address phase.
- Arbitration (evaluated every hready=1 edge; result loaded into grant_idx/hgrant):
  - Hold the current grant if hbusreq[grant_idx] & hlock[grant_idx].
  - Hold if hbusreq[grant_idx] & m_htrans[grant_idx] is SEQ or BUSY (burst protection, overrides MAXHOLD).
  - Hold if hbusreq[grant_idx] & (MAXHOLD==0 | hold_cnt<MAXHOLD-1).
  - Otherwise, round-robin: search from grant_idx+1 modulo NM; the first requesting master wins.
  - If no master requests, grant master 0.
- Hold counter:
  - Resets to 0 whenever grant_idx changes or no other master requests.
  - Otherwise increments per hready=1 cycle, saturating at MAXHOLD-1.
- Simultaneous requests are resolved by round-robin order only; requester index has no fixed priority.
- The granted master may drop hbusreq in the same cycle as it is granted; the grant then moves on the next hready=1 edge.
- Mux outputs are purely combinational from addr_owner/data_owner; zero latency.
- Out-of-range indices (NM < 2**MIW) never occur; the search covers 0..NM-1 only.
- Wrap-around: index NM-1 is followed by 0.

Test Plan:
- Reset then idle, all hbusreq=0 -> hgrant=0001, hmaster=0, htrans mirrors m_htrans[0], hmastlock=0.
- hbusreq=0110, grant at 0, hready=1 -> hgrant=0010 after edge 1, hmaster=1 after edge 2; master 1 holds until MAXHOLD=16 cycles, then hgrant=0100; with both still requesting, grants alternate 1,2,1,2.
- Master 3 issues NONSEQ addr 0x100 write, data 0xDEADBEEF; hready=0 for 3 cycles in the data phase -> hwdata stays 0xDEADBEEF from master 3 while hmaster already shows the next owner; no register changes while hready=0.
- Master 2 with hlock=1, hbusreq=1, master 1 requesting, MAXHOLD exceeded -> hgrant stays 0100 and hmastlock=1 until hlock drops, then hgrant=0010 after the next hready edge.
- Master 1 in a SEQ burst at hold limit with master 3 requesting -> no handover until master 1 drives NONSEQ/IDLE; then grant goes to 3.
- hreset pulsed mid-burst of master 2 -> next edge hgrant=0001, hmaster=0, hmastlock=0, hold_cnt=0.

Source files
------------

// File: rtl/ahb_arbiter_if.sv
// Shared AHB-Lite arbitration bundle: per-master request/control/data in, muxed slave-side bus out.
// Latency: none of its own; it only carries wires.
// Backpressure: hready from the slave flows through here to the arbiter and the masters.
//
// Port summary:
//   hbusreq/hlock                  per-master request and lock
//   m_haddr/m_htrans/m_hsize/...   per-master address/control/write data, master i at [i*W +: W]
//   hready                         slave ready
//   hgrant/hmaster/hmastlock       arbitration result
//   haddr/htrans/hsize/hwrite/hwdata  muxed shared bus
// Modports:
//   master  - the arbiter's view; it drives the shared bus.
//   slave   - the environment's view; it drives requests and reads the result.
interface ahb_arbiter_if #(
    parameter int NM  = 4,
    parameter int MIW = 3,
    parameter int DW  = 32,
    parameter int AW  = 32
);
    logic [NM-1:0]    hbusreq;
    logic [NM-1:0]    hlock;
    logic [NM*AW-1:0] m_haddr;
    logic [NM*2-1:0]  m_htrans;
    logic [NM*3-1:0]  m_hsize;
    logic [NM-1:0]    m_hwrite;
    logic [NM*DW-1:0] m_hwdata;
    logic             hready;
    logic [NM-1:0]    hgrant;
    logic [MIW-1:0]   hmaster;
    logic             hmastlock;
    logic [AW-1:0]    haddr;
    logic [1:0]       htrans;
    logic [2:0]       hsize;
    logic             hwrite;
    logic [DW-1:0]    hwdata;

    modport master (
        input  hbusreq, hlock, m_haddr, m_htrans, m_hsize, m_hwrite, m_hwdata, hready,
        output hgrant, hmaster, hmastlock, haddr, htrans, hsize, hwrite, hwdata
    );

    modport slave (
        output hbusreq, hlock, m_haddr, m_htrans, m_hsize, m_hwrite, m_hwdata, hready,
        input  hgrant, hmaster, hmastlock, haddr, htrans, hsize, hwrite, hwdata
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite arbiter with lock, burst protection and per-owner hold limit.
// Latency: grant registered one hready edge ahead of address ownership; bus muxes are combinational.
// Backpressure: hready=0 freezes every register (grant, owners, lock, hold counter).
//
// Ports: hclk (rising edge), hreset (synchronous, active high), bus (ahb_arbiter_if.master).
// State: grant_idx -> addr_owner (hmaster) -> data_owner pipeline, lock_q (hmastlock), hold_cnt.
module ahb_arbiter #(
    parameter int NM      = 4,
    parameter int MIW     = 3,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int MAXHOLD = 16
) (
    input  logic          hclk,
    input  logic          hreset,
    ahb_arbiter_if.master bus
);
    // Per-master arrays are padded to 2**MIW entries so an MIW-bit index
    // addresses them exactly; the padding entries are tied to zero.
    localparam int NS = 2 ** MIW;
    localparam int CW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
    localparam logic [CW-1:0] CNT_SAT = (MAXHOLD > 1) ? CW'(MAXHOLD - 1) : '0;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] SEQ  = 2'b11;

    logic [NS-1:0] req_v;
    logic [NS-1:0] lock_v;
    logic [NS-1:0] write_v;
    logic [AW-1:0] addr_a  [NS];
    logic [1:0]    trans_a [NS];
    logic [2:0]    size_a  [NS];
    logic [DW-1:0] wdata_a [NS];

    for (genvar g = 0; g < NS; g++) begin : g_unpack
        if (g < NM) begin : g_real
            assign req_v[g]   = bus.hbusreq[g];
            assign lock_v[g]  = bus.hlock[g];
            assign write_v[g] = bus.m_hwrite[g];
            assign addr_a[g]  = bus.m_haddr[g*AW +: AW];
            assign trans_a[g] = bus.m_htrans[g*2 +: 2];
            assign size_a[g]  = bus.m_hsize[g*3 +: 3];
            assign wdata_a[g] = bus.m_hwdata[g*DW +: DW];
        end else begin : g_pad
            assign req_v[g]   = 1'b0;
            assign lock_v[g]  = 1'b0;
            assign write_v[g] = 1'b0;
            assign addr_a[g]  = '0;
            assign trans_a[g] = IDLE;
            assign size_a[g]  = '0;
            assign wdata_a[g] = '0;
        end
    end

    logic [MIW-1:0] grant_idx, grant_nxt;
    logic [MIW-1:0] addr_owner;
    logic [MIW-1:0] data_owner;
    logic           lock_q, lock_nxt;
    logic [CW-1:0]  hold_cnt, cnt_nxt;

    // State register: everything advances only on hready-qualified edges.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            grant_idx  <= '0;
            addr_owner <= '0;
            data_owner <= '0;
            lock_q     <= 1'b0;
            hold_cnt   <= '0;
        end else if (bus.hready) begin
            grant_idx  <= grant_nxt;
            addr_owner <= grant_idx;
            data_owner <= addr_owner;
            lock_q     <= lock_nxt;
            hold_cnt   <= cnt_nxt;
        end
    end

    // Next-state: decide whether the current owner keeps the bus, else round-robin.
    logic           cur_req;
    logic           hold;
    logic           under_limit;
    logic           found;
    logic           others_req;
    logic [MIW-1:0] cand;
    logic [NS-1:0]  gmask;

    always_comb begin
        grant_nxt   = '0;
        found       = 1'b0;
        cand        = grant_idx;
        gmask       = '0;
        gmask[grant_idx] = 1'b1;
        cur_req     = req_v[grant_idx];
        under_limit = (MAXHOLD == 0) || (int'(hold_cnt) < MAXHOLD - 1);
        // Lock and an in-flight burst (SEQ/BUSY) both override the hold limit.
        hold = cur_req && (lock_v[grant_idx] ||
                           trans_a[grant_idx] == SEQ ||
                           trans_a[grant_idx] == BUSY ||
                           under_limit);
        if (hold) begin
            grant_nxt = grant_idx;
        end else begin
            // Walk grant_idx+1 .. grant_idx (wrapping at NM-1); the current
            // owner is visited last so it only wins when it is alone.
            for (int i = 0; i < NM; i++) begin
                cand = (cand == MIW'(NM - 1)) ? '0 : cand + 1'b1;
                if (!found && req_v[cand]) begin
                    found     = 1'b1;
                    grant_nxt = cand;
                end
            end
        end

        others_req = |(req_v & ~gmask);
        if (grant_nxt != grant_idx || !others_req) begin
            cnt_nxt = '0;
        end else if (hold_cnt != CNT_SAT) begin
            cnt_nxt = hold_cnt + 1'b1;
        end else begin
            cnt_nxt = hold_cnt;
        end

        lock_nxt = lock_v[grant_idx] && (trans_a[grant_idx] != IDLE);
    end

    // Outputs: grant decode plus zero-latency bus muxes.
    for (genvar g = 0; g < NM; g++) begin : g_grant
        assign bus.hgrant[g] = (grant_idx == MIW'(g));
    end

    assign bus.hmaster   = addr_owner;
    assign bus.hmastlock = lock_q;
    assign bus.haddr     = addr_a[addr_owner];
    assign bus.htrans    = trans_a[addr_owner];
    assign bus.hsize     = size_a[addr_owner];
    assign bus.hwrite    = write_v[addr_owner];
    assign bus.hwdata    = wdata_a[data_owner];
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: expectations queued as stimulus is driven, drained at check points.
// Latency: checks sample 1 time unit after the rising edge.
// Backpressure: hready is driven directly by the stimulus.
module tb_ahb_arbiter;
    localparam int NM = 4, MIW = 3, DW = 32, AW = 32, MAXHOLD = 16;
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

    logic hclk = 1'b0;
    logic hreset;

    ahb_arbiter_if #(.NM(NM), .MIW(MIW), .DW(DW), .AW(AW)) bus ();

    ahb_arbiter #(.NM(NM), .MIW(MIW), .DW(DW), .AW(AW), .MAXHOLD(MAXHOLD)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_m(input int i, input logic [1:0] trans, input logic [AW-1:0] addr,
                         input logic wr, input logic [DW-1:0] wdata);
        bus.m_htrans[i*2 +: 2]  = trans;
        bus.m_haddr[i*AW +: AW] = addr;
        bus.m_hwrite[i]         = wr;
        bus.m_hwdata[i*DW +: DW] = wdata;
        bus.m_hsize[i*3 +: 3]   = 3'd2;
    endtask

    task automatic expect_val(input string tag, input logic [63:0] val);
        sb.push_back('{tag: tag, val: val});
    endtask

    function automatic logic [63:0] observe(input string tag);
        case (tag)
            "hgrant":    return 64'(bus.hgrant);
            "hmaster":   return 64'(bus.hmaster);
            "hmastlock": return 64'(bus.hmastlock);
            "haddr":     return 64'(bus.haddr);
            "htrans":    return 64'(bus.htrans);
            "hwrite":    return 64'(bus.hwrite);
            "hwdata":    return 64'(bus.hwdata);
            default:     return 'x;
        endcase
    endfunction

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t        e;
            logic [63:0] o;
            e = sb.pop_front();
            o = observe(e.tag);
            n_checks++;
            assert (o === e.val) n_pass++;
            else $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
        end
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
    endtask

    initial begin
        hreset      = 1'b1;
        bus.hbusreq = '0;
        bus.hlock   = '0;
        bus.hready  = 1'b1;
        for (int i = 0; i < NM; i++) set_m(i, IDLE, 32'h1000 * (i + 1), 1'b0, 32'hA0 + i);

        // Reset state and idle default master.
        tick();
        hreset = 1'b0;
        expect_val("hgrant", 4'b0001);
        expect_val("hmaster", 0);
        expect_val("hmastlock", 0);
        drain();
        set_m(0, NONSEQ, 32'h1000, 1'b1, 32'hA0);
        #1;
        expect_val("htrans", NONSEQ);
        expect_val("haddr", 32'h1000);
        expect_val("hwrite", 1);
        drain();
        set_m(0, IDLE, 32'h1000, 1'b0, 32'hA0);
        tick();
        expect_val("hgrant", 4'b0001);
        expect_val("hmaster", 0);
        drain();

        // Round-robin with hold limit: masters 1 and 2 both requesting.
        bus.hbusreq = 4'b0110;
        tick();
        expect_val("hgrant", 4'b0010);
        expect_val("hmaster", 0);
        drain();
        tick();
        expect_val("hmaster", 1);
        drain();
        repeat (14) tick();
        expect_val("hgrant", 4'b0010);
        drain();
        tick();
        expect_val("hgrant", 4'b0100);
        expect_val("hmaster", 1);
        drain();
        repeat (15) tick();
        expect_val("hgrant", 4'b0100);
        drain();
        tick();
        expect_val("hgrant", 4'b0010);
        drain();
        repeat (15) tick();
        expect_val("hgrant", 4'b0010);
        drain();
        tick();
        expect_val("hgrant", 4'b0100);
        drain();

        // Master 3 write with a stalled data phase.
        bus.hbusreq = '0;
        do_reset();
        bus.hbusreq = 4'b1000;
        tick();
        expect_val("hgrant", 4'b1000);
        drain();
        bus.hbusreq = 4'b0010;
        set_m(3, NONSEQ, 32'h100, 1'b1, 32'h0);
        tick();
        expect_val("hgrant", 4'b0010);
        expect_val("hmaster", 3);
        expect_val("haddr", 32'h100);
        expect_val("htrans", NONSEQ);
        expect_val("hwrite", 1);
        drain();
        set_m(3, IDLE, 32'h100, 1'b1, 32'hDEADBEEF);
        set_m(1, NONSEQ, 32'h200, 1'b0, 32'hA1);
        tick();
        expect_val("hmaster", 1);
        expect_val("haddr", 32'h200);
        expect_val("hwdata", 32'hDEADBEEF);
        drain();
        bus.hready  = 1'b0;
        bus.hbusreq = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_val("hwdata", 32'hDEADBEEF);
            expect_val("hmaster", 1);
            expect_val("hgrant", 4'b0010);
            drain();
        end
        bus.hready = 1'b1;
        tick();
        expect_val("hgrant", 4'b0100);
        expect_val("hmaster", 1);
        expect_val("hwdata", 32'hA1);
        drain();

        // Locked owner keeps the bus past the hold limit.
        bus.hbusreq = '0;
        set_m(1, IDLE, 32'h2000, 1'b0, 32'hA1);
        set_m(3, IDLE, 32'h4000, 1'b0, 32'hA3);
        do_reset();
        bus.hbusreq = 4'b0100;
        bus.hlock   = 4'b0100;
        set_m(2, NONSEQ, 32'h3000, 1'b0, 32'hA2);
        tick();
        expect_val("hgrant", 4'b0100);
        drain();
        bus.hbusreq = 4'b0110;
        tick();
        expect_val("hmastlock", 1);
        expect_val("hmaster", 2);
        drain();
        repeat (20) tick();
        expect_val("hgrant", 4'b0100);
        expect_val("hmastlock", 1);
        drain();
        bus.hlock = '0;
        tick();
        expect_val("hgrant", 4'b0010);
        expect_val("hmastlock", 0);
        drain();

        // SEQ burst overrides the hold limit until NONSEQ.
        bus.hbusreq = '0;
        set_m(2, IDLE, 32'h3000, 1'b0, 32'hA2);
        do_reset();
        bus.hbusreq = 4'b0010;
        set_m(1, NONSEQ, 32'h2000, 1'b0, 32'hA1);
        tick();
        expect_val("hgrant", 4'b0010);
        drain();
        bus.hbusreq = 4'b1010;
        set_m(1, SEQ, 32'h2004, 1'b0, 32'hA1);
        repeat (20) tick();
        expect_val("hgrant", 4'b0010);
        drain();
        set_m(1, NONSEQ, 32'h2008, 1'b0, 32'hA1);
        tick();
        expect_val("hgrant", 4'b1000);
        drain();

        // Reset in the middle of a locked burst of master 2.
        bus.hbusreq = '0;
        set_m(1, IDLE, 32'h2000, 1'b0, 32'hA1);
        do_reset();
        bus.hbusreq = 4'b0100;
        bus.hlock   = 4'b0100;
        set_m(2, SEQ, 32'h3000, 1'b0, 32'hA2);
        tick();
        bus.hbusreq = 4'b0111;
        repeat (20) tick();
        expect_val("hgrant", 4'b0100);
        expect_val("hmastlock", 1);
        expect_val("hmaster", 2);
        drain();
        hreset      = 1'b1;
        bus.hbusreq = 4'b0011;
        bus.hlock   = '0;
        set_m(2, IDLE, 32'h3000, 1'b0, 32'hA2);
        tick();
        hreset = 1'b0;
        expect_val("hgrant", 4'b0001);
        expect_val("hmaster", 0);
        expect_val("hmastlock", 0);
        drain();
        // A cleared hold counter lets master 0 keep the grant for a full window.
        tick();
        expect_val("hgrant", 4'b0001);
        drain();
        repeat (14) tick();
        expect_val("hgrant", 4'b0001);
        drain();
        tick();
        expect_val("hgrant", 4'b0010);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
